// File: rtl/control_pkg.sv
// Shared types for the pipelined control unit: opcode encoding, ALU codes,
// and the per-instruction control bundle carried down the pipe.
package control_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'b0000,
        OP_STORE = 4'b0001,
        OP_MOVI  = 4'b0010,
        OP_MOV   = 4'b0011,
        OP_OUT   = 4'b0100,
        OP_ADD   = 4'b0101,
        OP_MOD   = 4'b0110,
        OP_LOAD  = 4'b0111,
        OP_AND   = 4'b1000,
        OP_SHR   = 4'b1001,
        OP_CMP   = 4'b1010,
        OP_BEQ   = 4'b1011,
        OP_JR    = 4'b1100,
        OP_BGT   = 4'b1101,
        OP_MUL   = 4'b1110,
        OP_JMP   = 4'b1111
    } opcode_e;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;  // shared by modulo and compare
    localparam logic [2:0] ALU_PASS = 3'b010;
    localparam logic [2:0] ALU_IMM  = 3'b011;  // MOVI and branch targets
    localparam logic [2:0] ALU_AND  = 3'b101;
    localparam logic [2:0] ALU_MUL  = 3'b110;
    localparam logic [2:0] ALU_SHR  = 3'b111;

    localparam logic [1:0] BK_NONE = 2'b00;
    localparam logic [1:0] BK_EQ   = 2'b01;
    localparam logic [1:0] BK_GT   = 2'b10;
    localparam logic [1:0] BK_UNC  = 2'b11;

    typedef struct packed {
        logic       we;
        logic       d2sel;
        logic [2:0] alu;
        logic       mwe;
        logic       rsel;
        logic       out;
        logic [1:0] bkind;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{we: 1'b0, d2sel: 1'b0, alu: ALU_ADD, mwe: 1'b0,
                                   rsel: 1'b0, out: 1'b0, bkind: BK_NONE};

endpackage

// File: rtl/control_decoder.sv
// Combinational opcode decoder: control bundle plus source-register use bits.
module control_decoder
    import control_pkg::*;
(
    input  logic [3:0] opcode,
    output ctrl_t      ctrl,
    output logic       uses_rs1,
    output logic       uses_rs2
);

    // Table decode; every field defaults to the NOP value so nothing is left X.
    always_comb begin
        ctrl     = CTRL_NOP;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        case (opcode_e'(opcode))
            OP_NOP:   uses_rs1 = 1'b0;
            OP_STORE: begin ctrl.mwe = 1'b1; ctrl.alu = ALU_PASS; uses_rs2 = 1'b1; end
            OP_MOVI:  begin ctrl.we = 1'b1; ctrl.d2sel = 1'b1; ctrl.alu = ALU_IMM; uses_rs1 = 1'b0; end
            OP_MOV:   begin ctrl.we = 1'b1; ctrl.alu = ALU_PASS; end
            OP_OUT:   begin ctrl.out = 1'b1; ctrl.alu = ALU_PASS; end
            OP_ADD:   begin ctrl.we = 1'b1; ctrl.alu = ALU_ADD; uses_rs2 = 1'b1; end
            OP_MOD:   begin ctrl.we = 1'b1; ctrl.alu = ALU_SUB; uses_rs2 = 1'b1; end
            OP_LOAD:  begin ctrl.we = 1'b1; ctrl.rsel = 1'b1; ctrl.alu = ALU_PASS; end
            OP_AND:   begin ctrl.we = 1'b1; ctrl.alu = ALU_AND; uses_rs2 = 1'b1; end
            OP_SHR:   begin ctrl.we = 1'b1; ctrl.alu = ALU_SHR; uses_rs2 = 1'b1; end
            OP_CMP:   begin ctrl.alu = ALU_SUB; uses_rs2 = 1'b1; end
            OP_BEQ:   begin ctrl.d2sel = 1'b1; ctrl.alu = ALU_IMM; ctrl.bkind = BK_EQ; end
            OP_JR:    begin ctrl.alu = ALU_PASS; ctrl.bkind = BK_UNC; end
            OP_BGT:   begin ctrl.d2sel = 1'b1; ctrl.alu = ALU_IMM; ctrl.bkind = BK_GT; end
            OP_MUL:   begin ctrl.we = 1'b1; ctrl.alu = ALU_MUL; uses_rs2 = 1'b1; end
            OP_JMP:   begin ctrl.d2sel = 1'b1; ctrl.alu = ALU_IMM; ctrl.bkind = BK_UNC; uses_rs1 = 1'b0; end
            default:  ctrl = CTRL_NOP;
        endcase
    end

endmodule

// File: rtl/control_pipeline.sv
// Pipelined control unit: decodes in D, carries the bundle through E/M/W,
// and raises stall/flush for RAW, load-use and taken-branch events.
// Optional feature macro: CTRL_FORWARD_EN adds forwardAE/forwardBE and lets
// ALU results bypass instead of stalling (only load-use still stalls).
module control_pipeline
    import control_pkg::*;
#(
    parameter int OPCODEWIDTH  = 4,
    parameter int ADDRESSWIDTH = 4,
    parameter int ALUCTRLWIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OPCODEWIDTH-1:0]  opcodeD,
    input  logic [ADDRESSWIDTH-1:0] rs1D,
    input  logic [ADDRESSWIDTH-1:0] rs2D,
    input  logic [ADDRESSWIDTH-1:0] rdD,
    input  logic                    branchTakenE,
    output logic                    stallF,
    output logic                    stallD,
    output logic                    flushD,
    output logic                    flushE,
    output logic                    writeEnableE,
    output logic                    writeEnableM,
    output logic                    writeEnableW,
    output logic [ALUCTRLWIDTH-1:0] aluControlE,
    output logic                    data2SelectorE,
    output logic [1:0]              branchKindE,
    output logic                    writeDataEnableM,
    output logic                    outFlagM,
    output logic                    resultSelectorW,
`ifdef CTRL_FORWARD_EN
    output logic [1:0]              forwardAE,
    output logic [1:0]              forwardBE,
`endif
    output logic [ADDRESSWIDTH-1:0] rdE,
    output logic [ADDRESSWIDTH-1:0] rdM,
    output logic [ADDRESSWIDTH-1:0] rdW
);

    ctrl_t ctrl_d, ctrl_e;
    logic  use1_d, use2_d;
    logic  we_m, mwe_m, out_m, rsel_m;
    logic  we_w, rsel_w;
    logic  match_e, load_use, raw;

    control_decoder u_dec (
        .opcode   (opcodeD),
        .ctrl     (ctrl_d),
        .uses_rs1 (use1_d),
        .uses_rs2 (use2_d)
    );

    // D->E register: reset or flush inserts a NOP bubble with rd cleared.
    always_ff @(posedge clk) begin
        if (!rst || flushE) begin
            ctrl_e <= CTRL_NOP;
            rdE    <= '0;
        end else begin
            ctrl_e <= ctrl_d;
            rdE    <= rdD;
        end
    end

    // E->M and M->W registers always advance; only the fields later stages need.
    always_ff @(posedge clk) begin
        if (!rst) begin
            we_m   <= 1'b0;
            mwe_m  <= 1'b0;
            out_m  <= 1'b0;
            rsel_m <= 1'b0;
            rdM    <= '0;
            we_w   <= 1'b0;
            rsel_w <= 1'b0;
            rdW    <= '0;
        end else begin
            we_m   <= ctrl_e.we;
            mwe_m  <= ctrl_e.mwe;
            out_m  <= ctrl_e.out;
            rsel_m <= ctrl_e.rsel;
            rdM    <= rdE;
            we_w   <= we_m;
            rsel_w <= rsel_m;
            rdW    <= rdM;
        end
    end

    assign writeEnableE     = ctrl_e.we;
    assign aluControlE      = ctrl_e.alu;
    assign data2SelectorE   = ctrl_e.d2sel;
    assign branchKindE      = ctrl_e.bkind;
    assign writeEnableM     = we_m;
    assign writeDataEnableM = mwe_m;
    assign outFlagM         = out_m;
    assign writeEnableW     = we_w;
    assign resultSelectorW  = rsel_w;

    // Source match against E's destination; unused sources never match.
    assign match_e  = (use1_d && (rdE == rs1D)) || (use2_d && (rdE == rs2D));
    assign load_use = ctrl_e.rsel && ctrl_e.we && match_e;

`ifdef CTRL_FORWARD_EN
    logic [ADDRESSWIDTH-1:0] rs1_e, rs2_e;
    logic                    use1_e, use2_e;

    // Source indices and use bits travel with the bundle for E-stage forwarding.
    always_ff @(posedge clk) begin
        if (!rst || flushE) begin
            rs1_e  <= '0;
            rs2_e  <= '0;
            use1_e <= 1'b0;
            use2_e <= 1'b0;
        end else begin
            rs1_e  <= rs1D;
            rs2_e  <= rs2D;
            use1_e <= use1_d;
            use2_e <= use2_d;
        end
    end

    // Bypass select per operand; the younger M result wins over W.
    always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        if (we_m && use1_e && (rdM == rs1_e))      forwardAE = 2'b10;
        else if (we_w && use1_e && (rdW == rs1_e)) forwardAE = 2'b01;
        if (we_m && use2_e && (rdM == rs2_e))      forwardBE = 2'b10;
        else if (we_w && use2_e && (rdW == rs2_e)) forwardBE = 2'b01;
    end

    assign raw = load_use;
`else
    logic match_m;
    assign match_m = (use1_d && (rdM == rs1D)) || (use2_d && (rdM == rs2D));
    // No bypass: any pending E/M write to a used source must stall; W is write-first.
    assign raw = load_use || (ctrl_e.we && match_e) || (we_m && match_m);
`endif

    // Hazard outputs; a taken branch cancels the stall and flushes D and E.
    always_comb begin
        stallF = raw && !branchTakenE;
        stallD = raw && !branchTakenE;
        flushD = branchTakenE;
        flushE = raw || branchTakenE;
    end

endmodule
